morse_tx_scheduler: RTL and testbench

MORSE_TX_SCHEDULER -- requirements
Module: morse_tx_scheduler

---
 rtl/morse_pkg.sv | 25 ++
 rtl/morse_letter_fifo.sv | 54 +++++
 rtl/morse_tx_scheduler.sv | 135 +++++++++++++
 tb/tb_morse_tx_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and widths for the Morse transmit scheduler.
// Holds the scheduler state enum, the letter length limit and the queue entry layout.
package morse_pkg;

  localparam int MORSE_MAX_LEN = 4;
  localparam int CODE_W        = 4;
  localparam int LEN_W         = 3;
  localparam int IDX_W         = $clog2(MORSE_MAX_LEN);
  localparam int ENTRY_W       = CODE_W + LEN_W;
  localparam int CNT_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MARK,
    SPACE,
    LGAP
  } state_e;

  // Lengths beyond the 4-bit code are meaningless, so they are capped on entry.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MORSE_MAX_LEN)) ? LEN_W'(MORSE_MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/morse_letter_fifo.sv
// Letter queue for the Morse scheduler: DEPTH entries of {code, len}, no bypass.
// A flush empties the queue and wins over a same-cycle push or pop.
module morse_letter_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        count_q;
  logic               do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/morse_tx_scheduler.sv
// Morse letter scheduler: queues letters and plays their dots/dashes on tick_i timing.
// Optional MORSE_TX_ABORT_EN adds abort_i, which flushes the queue and returns to IDLE.
module morse_tx_scheduler
  import morse_pkg::*;
#(
  parameter int FIFO_DEPTH       = 4,
  parameter int DASH_TICKS       = 3,
  parameter int SYM_GAP_TICKS    = 1,
  parameter int LETTER_GAP_TICKS = 3
) (
  input  logic              CLOCK50_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              req_valid_i,
  input  logic [CODE_W-1:0] req_code_i,
  input  logic [LEN_W-1:0]  req_len_i,
`ifdef MORSE_TX_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              req_ready_o,
  output logic              dotLed_o,
  output logic              dashLed_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc, mark_ticks;
  logic               dot_q, dot_d, dash_q, dash_d, done_q, done_d;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CODE_W-1:0]  fifo_code;
  logic [LEN_W-1:0]   fifo_len, len_m1;
  logic               fifo_full, fifo_empty, abort;

`ifdef MORSE_TX_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  morse_letter_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK50_i),
    .rst_i   (rst_i),
    .flush_i (abort),
    .push_i  (req_valid_i),
    .pop_i   (state_q == LOAD),
    .wdata_i ({req_code_i, clamp_len(req_len_i)}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign fifo_code   = fifo_rdata[ENTRY_W-1:LEN_W];
  assign fifo_len    = fifo_rdata[LEN_W-1:0];
  assign req_ready_o = !fifo_full;
  assign busy_o      = (state_q != IDLE) || !fifo_empty;
  assign dotLed_o    = dot_q;
  assign dashLed_o   = dash_q;
  assign done_o      = done_q;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    cnt_inc    = cnt_q + CNT_W'(1);
    len_m1     = fifo_len - LEN_W'(1);
    mark_ticks = code_q[idx_q] ? CNT_W'(DASH_TICKS) : CNT_W'(1);

    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        code_d = fifo_code;
        idx_d  = len_m1[IDX_W-1:0];
        state_d = (fifo_len == '0) ? LGAP : MARK;
      end
      MARK: if (tick_i) begin
        if (cnt_inc >= mark_ticks) state_d = (idx_q != '0) ? SPACE : LGAP;
        else cnt_d = cnt_inc;
      end
      SPACE: if (tick_i) begin
        if (cnt_inc >= CNT_W'(SYM_GAP_TICKS)) begin
          state_d = MARK;
          idx_d   = idx_q - IDX_W'(1);
        end else cnt_d = cnt_inc;
      end
      LGAP: if (tick_i) begin
        if (cnt_inc >= CNT_W'(LETTER_GAP_TICKS)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else cnt_d = cnt_inc;
      end
      default: state_d = IDLE;
    endcase

    // Every state entry starts a fresh tick count, so LOAD-cycle ticks never leak in.
    if (state_d != state_q) cnt_d = '0;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    // LEDs are registered from the next state so they switch cleanly on the clock edge.
    dot_d  = (state_d == MARK) && !code_d[idx_d];
    dash_d = (state_d == MARK) && code_d[idx_d];
  end

  always_ff @(posedge CLOCK50_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      code_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Self-checking bench for morse_tx_scheduler: a segment-list reference model checked every
// cycle, plus hand-computed timings for the standard letters. Honours MORSE_TX_ABORT_EN.
module tb_morse_tx_scheduler;

  localparam int DEPTH = 4;
  localparam int DASH  = 3;
  localparam int SGAP  = 1;
  localparam int LGAPT = 3;

  logic       clk = 1'b0;
  logic       rst, tick, valid;
  logic [3:0] code;
  logic [2:0] len;
  logic       ready, dot, dash, busy, done;
`ifdef MORSE_TX_ABORT_EN
  logic       abort;
`endif

  int vectors = 0, miscompares = 0;
  int cycleNo = 0, phase = 0;
  bit checkEn = 0;
  int dotHigh, dashHigh, dashRise, doneCount, lastDoneCycle;
  logic prevDash = 1'b0;

  always #5 clk = ~clk;

  morse_tx_scheduler #(
    .FIFO_DEPTH(DEPTH), .DASH_TICKS(DASH), .SYM_GAP_TICKS(SGAP), .LETTER_GAP_TICKS(LGAPT)
  ) dut (
    .CLOCK50_i   (clk),
    .rst_i       (rst),
    .tick_i      (tick),
    .req_valid_i (valid),
    .req_code_i  (code),
    .req_len_i   (len),
`ifdef MORSE_TX_ABORT_EN
    .abort_i     (abort),
`endif
    .req_ready_o (ready),
    .dotLed_o    (dot),
    .dashLed_o   (dash),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Reference model: a letter expands into a list of (led, ticks) segments played in order.
  typedef struct { int kind; int ticks; } seg_t;
  typedef struct { logic [3:0] c; int l; } letter_t;
  letter_t mq[$];
  seg_t    segs[$];
  bit      mRun, mLoad, mDone;
  int      mCnt;

  always @(posedge clk or posedge rst) begin
    bit accept, nextLoad, nextDone, abortNow;
    letter_t nl, cur;
    if (rst) begin
      mq.delete(); segs.delete();
      mRun = 0; mLoad = 0; mDone = 0; mCnt = 0;
    end else begin
      abortNow = 0;
`ifdef MORSE_TX_ABORT_EN
      abortNow = abort;
`endif
      accept   = valid && (mq.size() < DEPTH);
      nextLoad = 0;
      nextDone = 0;
      if (abortNow) begin
        mq.delete(); segs.delete();
        mRun = 0; mLoad = 0; mCnt = 0;
      end else begin
        if (mRun) begin
          if (tick) begin
            mCnt++;
            if (mCnt == segs[0].ticks) begin
              void'(segs.pop_front());
              mCnt = 0;
              if (segs.size() == 0) begin mRun = 0; nextDone = 1; end
            end
          end
        end else if (mLoad) begin
          cur = mq.pop_front();
          for (int i = cur.l - 1; i >= 0; i--) begin
            segs.push_back('{cur.c[i] ? 1 : 0, cur.c[i] ? DASH : 1});
            if (i > 0) segs.push_back('{2, SGAP});
          end
          segs.push_back('{2, LGAPT});
          mRun = 1; mCnt = 0;
        end else if (mq.size() > 0) nextLoad = 1;
        if (accept) begin
          nl.c = code;
          nl.l = (len > 4) ? 4 : int'(len);
          mq.push_back(nl);
        end
      end
      mLoad = nextLoad;
      mDone = nextDone;
    end
  end

  // Per-cycle comparison plus the statistics the directed checks look at.
  always @(negedge clk) begin
    logic [4:0] act, exp;
    cycleNo++;
    if (checkEn && !rst) begin
      act = {ready, dot, dash, busy, done};
      exp = {mq.size() < DEPTH, mRun && segs[0].kind == 0, mRun && segs[0].kind == 1,
             mRun || mLoad || mq.size() > 0, mDone};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL cycleCheck at cycle %0d: got %b want %b (ready,dot,dash,busy,done)",
                 cycleNo, act, exp);
      end
    end
    if (dot) dotHigh++;
    if (dash) dashHigh++;
    if (dash && !prevDash) dashRise++;
    if (done) begin doneCount++; lastDoneCycle = cycleNo; end
    prevDash = dash;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
    end
  endtask

  task automatic clearStats();
    dotHigh = 0; dashHigh = 0; dashRise = 0; doneCount = 0; lastDoneCycle = -1;
  endtask

  task automatic stepCycle();
    @(negedge clk); #1;
    valid = 1'b0;
    tick  = (phase % 4 == 3);
    phase++;
`ifdef MORSE_TX_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // Holds a request valid until accepted; startPhase >= 0 realigns the tick timebase.
  task automatic applyStimulus(input logic [3:0] c, input logic [2:0] l, input int startPhase,
                               output int acceptCycle);
    int tries = 0;
    if (startPhase >= 0) phase = startPhase;
    acceptCycle = -1;
    do begin
      stepCycle();
      valid = 1'b1; code = c; len = l;
      if (ready) acceptCycle = cycleNo;
      tries++;
    end while (acceptCycle < 0 && tries < 300);
    if (acceptCycle < 0) checkOutput("acceptTimeout", 0, 1);
  endtask

  initial begin
    int t0, t1, t2, t5;
    rst = 1'b1; tick = 1'b0; valid = 1'b0; code = '0; len = '0;
`ifdef MORSE_TX_ABORT_EN
    abort = 1'b0;
`endif
    clearStats();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetReady", ready, 1);
    checkOutput("resetLeds", {dot, dash}, 0);
    checkOutput("resetBusyDone", {busy, done}, 0);
    rst = 1'b0;
    checkEn = 1;
    runCycles(3);

    // Letter A: dot, space, dash, gap; ticks at cycles 3,7,11,...
    clearStats();
    applyStimulus(4'b0001, 3'd2, 0, t0);
    runCycles(40);
    checkOutput("A_dotCycles", dotHigh, 1);
    checkOutput("A_dashCycles", dashHigh, 12);
    checkOutput("A_doneCount", doneCount, 1);
    checkOutput("A_doneOffset", lastDoneCycle - t0, 32);

    // Empty letter with a tick landing on LOAD, which must not count.
    clearStats();
    applyStimulus(4'b0110, 3'd0, 1, t0);
    runCycles(20);
    checkOutput("len0_leds", dotHigh + dashHigh, 0);
    checkOutput("len0_doneOffset", lastDoneCycle - t0, 15);

    // Length 7 clamps to 4: four dashes.
    clearStats();
    applyStimulus(4'b1111, 3'd7, 0, t0);
    runCycles(80);
    checkOutput("len7_dashes", dashRise, 4);
    checkOutput("len7_dots", dotHigh, 0);
    checkOutput("len7_doneOffset", lastDoneCycle - t0, 72);

    // Queue fills behind a long letter; the fifth waits for the first pop.
    clearStats();
    applyStimulus(4'b1111, 3'd4, 0, t0);
    applyStimulus(4'b0001, 3'd2, -1, t1);
    applyStimulus(4'b0001, 3'd1, -1, t2);
    applyStimulus(4'b0000, 3'd1, -1, t2);
    applyStimulus(4'b1010, 3'd4, -1, t2);
    stepCycle();
    checkOutput("fullReadyLow", ready, 0);
    applyStimulus(4'b0000, 3'd0, -1, t5);
    checkOutput("fifthAcceptOffset", t5 - t0, 74);
    for (int i = 0; i < 1000 && doneCount < 6; i++) stepCycle();
    checkOutput("batchDoneCount", doneCount, 6);
    runCycles(5);

    // Reset in the middle of a dash drops everything.
    applyStimulus(4'b1111, 3'd4, 0, t0);
    applyStimulus(4'b0001, 3'd2, -1, t1);
    applyStimulus(4'b0011, 3'd2, -1, t2);
    runCycles(4);
    checkOutput("dashBeforeReset", dash, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstDashDrop", dash, 0);
    checkOutput("rstBusyDone", {busy, done}, 0);
    checkOutput("rstReady", ready, 1);
    stepCycle();
    rst = 1'b0;
    clearStats();
    runCycles(30);
    checkOutput("postRstActivity", dotHigh + dashHigh + doneCount, 0);

`ifdef MORSE_TX_ABORT_EN
    // Abort during the first inter-symbol space with two letters queued.
    clearStats();
    applyStimulus(4'b1010, 3'd4, 0, t0);
    applyStimulus(4'b0001, 3'd2, -1, t1);
    applyStimulus(4'b0011, 3'd2, -1, t2);
    runCycles(10);
    stepCycle();
    abort = 1'b1;
    stepCycle();
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortLeds", {dot, dash}, 0);
    runCycles(30);
    checkOutput("abortNoDone", doneCount, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
